// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map types and region decode for the store queue
package mem_map_pkg;
   localparam int ST_ADDR_W  = 16;
   localparam int ST_DATA_W  = 16;
   localparam int REGION_MSB = ST_ADDR_W - 1;
   localparam int REGION_LSB = ST_ADDR_W - 2;
   localparam int LOCAL_W    = ST_ADDR_W - 2;

   typedef enum logic [1:0] {
      REG_0    = 2'b00,
      REG_1    = 2'b01,
      REG_2    = 2'b10,
      REG_NONE = 2'b11
   } region_e;

   typedef struct packed {
      region_e              sel;
      logic [LOCAL_W-1:0]   laddr;
      logic [ST_DATA_W-1:0] data;
   } st_entry_t;

   function automatic region_e decode_region(input logic [ST_ADDR_W-1:0] addr);
      return region_e'(addr[REGION_MSB:REGION_LSB]);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers are log2(DEPTH) wide so they wrap without explicit compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/mem_store_queue.sv
// rtl/mem_store_queue.sv - in-order store buffer feeding the 3-way write decoder
module mem_store_queue
   import mem_map_pkg::*;
#(
   parameter int DATA_W = ST_DATA_W,
   parameter int ADDR_W = ST_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid_i,
   output logic                     st_ready_o,
   input  logic [ADDR_W-1:0]        st_addr_i,
   input  logic [DATA_W-1:0]        st_data_i,
   output logic                     wr_valid_o,
   output logic [1:0]               wr_sel_o,
   output logic [ADDR_W-3:0]        wr_addr_o,
   output logic [DATA_W-1:0]        wr_data_o,
   input  logic [2:0]               region_ready_i,
   output logic                     err_o,
   output logic [ADDR_W-1:0]        err_addr_o,
   input  logic                     err_clr_i,
   output logic [$clog2(DEPTH):0]   count_o
);
   region_e          st_region;
   st_entry_t        in_entry, fifo_rdata, head, last_q;
   logic             accept, unmapped, push, pop;
   logic             fifo_full, fifo_empty;
   logic [3:0]       ready_ext;
   logic             err_q;
   logic [ADDR_W-1:0] err_addr_q;

   assign st_region = decode_region(st_addr_i);
   assign accept    = st_valid_i && st_ready_o;
   assign unmapped  = accept && (st_region == REG_NONE);
   assign push      = accept && !unmapped;

   assign in_entry.sel   = st_region;
   assign in_entry.laddr = st_addr_i[LOCAL_W-1:0];
   assign in_entry.data  = st_data_i;

   sync_fifo #(
      .WIDTH ($bits(st_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_entry),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (count_o)
   );

   // When empty the outputs replay the last issued entry rather than stale RAM
   assign head       = fifo_empty ? last_q : fifo_rdata;
   assign ready_ext  = {1'b0, region_ready_i};
   assign st_ready_o = !fifo_full;
   assign wr_valid_o = !fifo_empty;
   assign pop        = wr_valid_o && ready_ext[head.sel];

   assign wr_sel_o   = head.sel;
   assign wr_addr_o  = head.laddr;
   assign wr_data_o  = head.data;
   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q     <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         if (pop) last_q <= fifo_rdata;
         // A new unmapped store beats a same-cycle clear and becomes the held address
         if (unmapped) begin
            err_q <= 1'b1;
            if (!err_q || err_clr_i) err_addr_q <= st_addr_i;
         end else if (err_clr_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
         end
      end
   end
endmodule
